spi_reg_target: RTL

SPI target (slave-side) bridge converting SPI mode-0 frames from `spi_master` into single-cycle register read/write strobes on a parallel register port. It samples `cs_b`, `sclk` and `mosi` in the system clock domain, decodes a command byte followed by one or more data bytes, and drives `miso` back to the master. It sits between the SPI pins and a register bank in the device model, replacing the simplistic behavioural slave in the `spi_master` testbench.

---
 rtl/spi_reg_target.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_reg_target
// Function : SPI mode-0 target that turns command/data byte frames into
//            single-cycle register write/read strobes. Pins are synchronised
//            into clk; byte 0 carries R/W and start address, later bytes are
//            burst data with wrapping address increment.
// Revision : 1.0  initial release
// ============================================================================
module spi_reg_target #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              cs_b,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              wr_en,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   cs_d;
    logic                   sclk_d;
    logic                   armed;

    logic [2:0] bit_cnt;
    logic [6:0] rx;
    logic [6:0] tx;
    logic       is_read;

    logic       cs_s, sclk_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_fall;
    logic       in_frame, byte_done, cs_end;
    logic [2:0] cnt_next;
    logic [7:0] byte_in;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign in_frame  = (state != IDLE);
    assign cnt_next  = bit_cnt + {2'b00, sclk_rise};
    assign byte_done = in_frame & sclk_rise & (bit_cnt == 3'd7);
    assign cs_end    = in_frame & cs_s;
    assign byte_in   = {rx, mosi_s};
    assign miso_oe   = in_frame;

    // Pin synchronisers plus an arming flag: a frame already running when
    // reset releases must not start a transaction, so a real high cs_b has to
    // be seen (after the chain holds genuine samples) before a fall counts.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            fill      <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
            armed     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_b};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
            if (fill[SYNC_STAGES-1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: cs_b high always wins and returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall && armed) state_next = CMD;
            CMD:     if (cs_s) state_next = IDLE;
                     else if (byte_done) state_next = DATA;
            DATA:    if (cs_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte assembly, strobe generation, address walk and miso shifting.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bit_cnt   <= 3'd0;
            rx        <= 7'd0;
            tx        <= 7'd0;
            is_read   <= 1'b0;
            miso      <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'd0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            frame_err <= 1'b0;
            if (wr_en) begin
                reg_addr <= reg_addr + ADDR_W'(1);
            end
            if (!in_frame) begin
                bit_cnt <= 3'd0;
                is_read <= 1'b0;
                miso    <= 1'b0;
                tx      <= 7'd0;
            end else begin
                if (sclk_rise) begin
                    rx      <= byte_in[6:0];
                    bit_cnt <= cnt_next;
                end
                if (byte_done) begin
                    if (state == CMD) begin
                        reg_addr <= byte_in[ADDR_W-1:0];
                        is_read  <= byte_in[7];
                        rd_en    <= byte_in[7];
                    end else if (is_read) begin
                        // Prefetch the next register for the following byte.
                        reg_addr <= reg_addr + ADDR_W'(1);
                        rd_en    <= 1'b1;
                    end else begin
                        wr_en     <= 1'b1;
                        reg_wdata <= byte_in;
                    end
                end
                // The fall right after a byte boundary keeps the freshly
                // loaded MSB; only falls inside a byte advance the shifter.
                if (sclk_fall && (bit_cnt != 3'd0) && is_read && (state == DATA)) begin
                    miso <= tx[6];
                    tx   <= {tx[5:0], 1'b0};
                end
                if (cs_end) begin
                    frame_err <= (cnt_next != 3'd0);
                    miso      <= 1'b0;
                end
            end
            if (rd_en) begin
                tx   <= rd_data[6:0];
                miso <= in_frame & ~cs_s & rd_data[7];
            end
        end
    end

endmodule
`default_nettype wire
